// File: rtl/mem_control_pkg.sv
// Shared memory-controller types: DRAM command encoding and scheduler FSM states.
package mem_control;

    typedef enum logic [2:0] {
        READ      = 3'd0,
        WRITE     = 3'd1,
        ACTIVATE  = 3'd2,
        PRECHARGE = 3'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PRE   = 3'd2,
        ACT   = 3'd3,
        RW    = 3'd4
    } state_e;

    // Index width that stays legal (>=1) for single-entry dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/address_parser.sv
// Splits a physical address into column, bank, bank group and row fields
// above a 3-bit byte offset.
module address_parser #(
    parameter int ROW_BITS   = 8,
    parameter int COL_BITS   = 4,
    parameter int BA_W       = 2,
    parameter int BG_W       = 1,
    parameter int PADDR_BITS = 19
) (
    input  logic [PADDR_BITS-1:0] addr_i,
    output logic [COL_BITS-1:0]   col_o,
    output logic [BA_W-1:0]       bank_o,
    output logic [BG_W-1:0]       bg_o,
    output logic [ROW_BITS-1:0]   row_o
);

    localparam int COL_LSB = 3;
    localparam int BA_LSB  = COL_LSB + COL_BITS;
    localparam int BG_LSB  = BA_LSB + BA_W;
    localparam int ROW_LSB = BG_LSB + BG_W;
    localparam int USED    = ROW_LSB + ROW_BITS;

    assign col_o  = addr_i[BA_LSB-1:COL_LSB];
    assign bank_o = addr_i[BG_LSB-1:BA_LSB];
    assign bg_o   = addr_i[ROW_LSB-1:BG_LSB];
    assign row_o  = addr_i[USED-1:ROW_LSB];

    // Byte offset and any spare high bits do not address a line.
    logic unused_addr;
    if (PADDR_BITS > USED) begin : g_hi
        assign unused_addr = ^{addr_i[COL_LSB-1:0], addr_i[PADDR_BITS-1:USED]};
    end else begin : g_nohi
        assign unused_addr = ^addr_i[COL_LSB-1:0];
    end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Single-request DRAM bank scheduler: open-row check, PRE/ACT/column sequencing
// with per-bank timers and a global column-gap counter; all outputs registered.
module bank_cmd_scheduler
    import mem_control::*;
#(
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int BANK_GROUPS        = 2,
    parameter int BANKS_PER_GROUP    = 4,
    parameter int PADDR_BITS         = 19,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_CYCLES       = 8,
    localparam int BG_W  = clog2_min1(BANK_GROUPS),
    localparam int BA_W  = clog2_min1(BANKS_PER_GROUP)
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [PADDR_BITS-1:0] req_addr_in,
    input  logic                  req_write_in,
    input  logic [7:0][63:0]      req_data_in,
    output logic [2:0]            cmd_out,
    output logic                  valid_out,
    output logic [BG_W-1:0]       bank_group_out,
    output logic [BA_W-1:0]       bank_out,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [COL_BITS-1:0]   col_out,
    output logic [7:0][63:0]      val_out
);

    localparam int NB    = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BI_W  = clog2_min1(NB);
    localparam int TMAX  = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                           ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int TMR_W = clog2_min1(TMAX + 1);
    localparam int GAP_W = clog2_min1(BURST_CYCLES + 1);

    state_e state_q, state_d;

    // Held request
    logic [COL_BITS-1:0] rq_col_q;
    logic [BA_W-1:0]     rq_ba_q;
    logic [BG_W-1:0]     rq_bg_q;
    logic [ROW_BITS-1:0] rq_row_q;
    logic                rq_wr_q;
    logic [7:0][63:0]    rq_data_q;

    // Per-bank state
    logic [TMR_W-1:0]    tmr_q      [NB];
    logic [ROW_BITS-1:0] open_row_q [NB];
    logic [NB-1:0]       open_q;
    logic [GAP_W-1:0]    gap_q;

    // Registered outputs
    logic                ready_q;
    logic                valid_q;
    cmd_e                cmd_q;
    logic [BG_W-1:0]     bg_q;
    logic [BA_W-1:0]     ba_q;
    logic [ROW_BITS-1:0] row_q;
    logic [COL_BITS-1:0] col_q;
    logic [7:0][63:0]    val_q;

    logic [COL_BITS-1:0] dec_col;
    logic [BA_W-1:0]     dec_ba;
    logic [BG_W-1:0]     dec_bg;
    logic [ROW_BITS-1:0] dec_row;

    logic            hs;
    logic            issue;
    cmd_e            issue_cmd;
    logic [BI_W-1:0] bidx;
    logic            is_col;

    address_parser #(
        .ROW_BITS   (ROW_BITS),
        .COL_BITS   (COL_BITS),
        .BA_W       (BA_W),
        .BG_W       (BG_W),
        .PADDR_BITS (PADDR_BITS)
    ) u_parser (
        .addr_i (req_addr_in),
        .col_o  (dec_col),
        .bank_o (dec_ba),
        .bg_o   (dec_bg),
        .row_o  (dec_row)
    );

    assign hs     = req_valid_in && ready_q;
    assign bidx   = BI_W'(rq_bg_q) * BI_W'(BANKS_PER_GROUP) + BI_W'(rq_ba_q);
    assign is_col = issue && (issue_cmd == READ || issue_cmd == WRITE);

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        issue_cmd = READ;
        case (state_q)
            IDLE:  if (hs) state_d = CHECK;
            CHECK: begin
                if (!open_q[bidx])                       state_d = ACT;
                else if (open_row_q[bidx] == rq_row_q)   state_d = RW;
                else                                     state_d = PRE;
            end
            PRE: if (tmr_q[bidx] == '0) begin
                issue     = 1'b1;
                issue_cmd = PRECHARGE;
                state_d   = ACT;
            end
            ACT: if (tmr_q[bidx] == '0) begin
                issue     = 1'b1;
                issue_cmd = ACTIVATE;
                state_d   = RW;
            end
            RW: if (tmr_q[bidx] == '0 && gap_q == '0) begin
                issue     = 1'b1;
                issue_cmd = rq_wr_q ? WRITE : READ;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int b = 0; b < NB; b++) begin
                tmr_q[b]      <= '0;
                open_row_q[b] <= '0;
            end
            open_q    <= '0;
            gap_q     <= '0;
            rq_col_q  <= '0;
            rq_ba_q   <= '0;
            rq_bg_q   <= '0;
            rq_row_q  <= '0;
            rq_wr_q   <= 1'b0;
            rq_data_q <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            cmd_q     <= READ;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            val_q     <= '0;
        end else begin
            // Load wins over decrement only for the bank being commanded.
            for (int b = 0; b < NB; b++) begin
                if (issue && BI_W'(b) == bidx && issue_cmd == PRECHARGE) begin
                    tmr_q[b]  <= TMR_W'(PRECHARGE_LATENCY);
                    open_q[b] <= 1'b0;
                end else if (issue && BI_W'(b) == bidx && issue_cmd == ACTIVATE) begin
                    tmr_q[b]      <= TMR_W'(ACTIVATION_LATENCY);
                    open_q[b]     <= 1'b1;
                    open_row_q[b] <= rq_row_q;
                end else if (tmr_q[b] != '0) begin
                    tmr_q[b] <= tmr_q[b] - 1'b1;
                end
            end

            if (is_col)            gap_q <= GAP_W'(BURST_CYCLES);
            else if (gap_q != '0)  gap_q <= gap_q - 1'b1;

            if (hs) begin
                rq_col_q  <= dec_col;
                rq_ba_q   <= dec_ba;
                rq_bg_q   <= dec_bg;
                rq_row_q  <= dec_row;
                rq_wr_q   <= req_write_in;
                rq_data_q <= req_data_in;
            end

            ready_q <= (state_d == IDLE);
            valid_q <= issue;
            if (issue) begin
                cmd_q <= issue_cmd;
                bg_q  <= rq_bg_q;
                ba_q  <= rq_ba_q;
                row_q <= rq_row_q;
                col_q <= rq_col_q;
            end
            if (issue && issue_cmd == WRITE) val_q <= rq_data_q;
        end
    end

    assign req_ready_out  = ready_q;
    assign valid_out      = valid_q;
    assign cmd_out        = cmd_q;
    assign bank_group_out = bg_q;
    assign bank_out       = ba_q;
    assign row_out        = row_q;
    assign col_out        = col_q;
    assign val_out        = val_q;

endmodule
